// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider plus horizontal/vertical raster counters
// with registered sync and visible-window decodes.
// The decodes are computed from the next counter values, so hSync, vSync and
// bright change on the same clock as hCount/vCount with no skew.
// Optional feature macro: VGA_SYNC_DELAY_EN. When it is defined, hSync, vSync
// and bright are delayed by one extra pixel period. This lines them up with a
// pixel source whose lookup has one cycle of latency.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_start
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_L = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_L = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_S  = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_E  = 10'(H_ACT_END);
  localparam logic [9:0] V_ACT_S  = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_E  = 10'(V_ACT_END);

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       bright_q, bright_d;
  logic       fstart_q, fstart_d;
  logic       tick;

  // Next state: advance the divider, step the raster on a tick, and decode the next position.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    tick     = en && (div_q == DIV_LAST);
    div_d    = div_q;
    h_d      = h_q;
    v_d      = v_q;
    fstart_d = 1'b0;

    if (en) begin
      div_d = tick ? 4'd0 : div_q + 4'd1;
    end

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d      = 10'd0;
        v_d      = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        fstart_d = (v_q == V_LAST);
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    hsync_d  = (h_d >= H_SYNC_L);
    vsync_d  = (v_d >= V_SYNC_L);
    bright_d = (h_d >= H_ACT_S) && (h_d < H_ACT_E) &&
               (v_d >= V_ACT_S) && (v_d < V_ACT_E);
  end

  // Divider, counters and decodes. Reset aborts the raster immediately and returns it to (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= 4'd0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      fstart_q <= fstart_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_dly_q;
  logic vsync_dly_q;
  logic bright_dly_q;

  // One-pixel delay of the decodes. It advances only on pixel ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_dly_q  <= 1'b0;
      vsync_dly_q  <= 1'b0;
      bright_dly_q <= 1'b0;
    end else if (tick) begin
      hsync_dly_q  <= hsync_q;
      vsync_dly_q  <= vsync_q;
      bright_dly_q <= bright_q;
    end
  end

  assign hSync  = hsync_dly_q;
  assign vSync  = vsync_dly_q;
  assign bright = bright_dly_q;
`else
  assign hSync  = hsync_q;
  assign vSync  = vsync_q;
  assign bright = bright_q;
`endif

  assign pix_tick    = tick;
  assign hCount      = h_q;
  assign vCount      = v_q;
  // The flop clears itself on the next edge. Gating with en keeps the pulse quiet while frozen.
  assign frame_start = fstart_q & en;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel; legal range 2..16.
REQ-002 Parameter H_TOTAL, default 800: pixels per line, counted 0..H_TOTAL-1.
REQ-003 Parameters H_SYNC=96, H_ACT_START=144, H_ACT_END=784: hSync low for hCount<H_SYNC; visible for H_ACT_START<=hCount<H_ACT_END.
REQ-004 Parameter V_TOTAL, default 525: lines per frame, counted 0..V_TOTAL-1.
REQ-005 Parameters V_SYNC=2, V_ACT_START=35, V_ACT_END=515: vSync low for vCount<V_SYNC; visible for V_ACT_START<=vCount<V_ACT_END.
REQ-006 clk  input  1  system clock, 100 MHz.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  run enable; low freezes all counters and the divider.
REQ-009 pix_tick  output  1  one-clk pulse marking each pixel advance.
REQ-010 hCount  output  10  current pixel column.
REQ-011 vCount  output  10  current line.
REQ-012 hSync  output  1  horizontal sync, active low.
REQ-013 vSync  output  1  vertical sync, active low.
REQ-014 bright  output  1  high only inside the visible window.
REQ-015 frame_start  output  1  one-clk pulse when counters wrap to (0,0).

Function
REQ-016 Divider counts 0..CLK_DIV-1 on every clk while en=1; pix_tick=1 in the cycle divider==CLK_DIV-1, else 0.
REQ-017 On pix_tick: hCount increments; at H_TOTAL-1 it wraps to 0 and vCount increments.
REQ-018 vCount wraps from V_TOTAL-1 to 0 on the same tick that hCount wraps.
REQ-019 hCount, vCount, hSync, vSync, bright are all registered; sync/bright reflect the counter values in that same cycle (no skew between counters and decodes).
REQ-020 frame_start=1 for exactly the one clk in which hCount and vCount both take value 0 after a wrap; not asserted on reset release.
REQ-021 en=0: divider, counters and all registered outputs hold; pix_tick and frame_start forced 0.
REQ-022 en re-asserted: divider resumes from its held value; no tick is skipped or duplicated.
REQ-023 Counter arithmetic is 10-bit unsigned; values >=H_TOTAL or >=V_TOTAL are never output.
REQ-024 Frame period = CLK_DIV*H_TOTAL*V_TOTAL clks (default 1,680,000).

Reset
REQ-025 rst=0 asynchronously forces divider=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0, pix_tick=0, frame_start=0.
REQ-026 rst asserted mid-line or mid-frame aborts immediately; after release, the first pix_tick occurs CLK_DIV clks later and counting restarts from (0,0).

Configuration
REQ-027 Macro VGA_SYNC_DELAY_EN defined: hSync, vSync, bright are delayed one additional pix_tick period (registered on pix_tick) relative to hCount/vCount, aligning with one-cycle-latency sprite ROM lookups; reset value of delay registers is 0.
REQ-028 Macro VGA_SYNC_DELAY_EN undefined: no delay stage; REQ-019 alignment holds.

Verification
REQ-029 Reset release, en=1, defaults -> pix_tick every 4 clks; hCount 0->1 on first tick; hSync low for hCount 0..95, high at 96.
REQ-030 Run to hCount=799, vCount=9 -> next tick gives hCount=0, vCount=10; bright=0 throughout line 9..10 horizontal blank.
REQ-031 Run one full frame -> frame_start pulses once after 1,680,000 clks; vSync low only on lines 0..1; bright first high at (144,35), last high at (783,514).
REQ-032 en=0 for 10 clks at hCount=300 -> hCount stays 300, pix_tick=0; after en=1, tick spacing exactly 4 clks counting held divider phase.
REQ-033 rst pulsed low at hCount=500, vCount=200 -> all outputs 0 same cycle (asynchronous); count restarts from (0,0), no frame_start.
REQ-034 VGA_SYNC_DELAY_EN defined -> bright rises one pixel period after hCount reaches 144 on line 35.
